// File: rtl/rs485_pkg.sv
// Shared RS-485 definitions: state encoding, oversampling and sample ticks, frame size, default parity.
// Intended for both the receive and transmit sides of the link.
package rs485_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } rx_state_e;

   localparam int OVERSAMPLE = 16;
   localparam int TICK_W     = $clog2(OVERSAMPLE);

   localparam logic [TICK_W-1:0] SAMPLE_T0 = TICK_W'(6);
   localparam logic [TICK_W-1:0] SAMPLE_T1 = TICK_W'(7);
   localparam logic [TICK_W-1:0] SAMPLE_T2 = TICK_W'(8);

   localparam int   FRAME_BITS      = 11;
   localparam logic PARITY_MODE_DEF = 1'b0;

   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/rs485_rx_sync.sv
// Two-flop synchronizer plus delay flop on the rx line, with falling-edge detect; all flops reset high.
// Latency: rx_s_o lags rx_i by 2 clocks; no backpressure.
module rs485_rx_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic rx_i,
   output logic rx_s_o,
   output logic fall_o
);

   logic meta_q;
   logic sync_q;
   logic dly_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= 1'b1;
         sync_q <= 1'b1;
         dly_q  <= 1'b1;
      end else begin
         meta_q <= rx_i;
         sync_q <= meta_q;
         dly_q  <= sync_q;
      end
   end

   assign rx_s_o = sync_q;
   assign fall_o = ~sync_q & dly_q;

endmodule

// File: rtl/rs485_rx.sv
// RS-485 receiver: start, 8 data bits LSB first, parity, stop; 16x oversampled with 3-tap majority vote.
// Latency: rdsig 169 clocks after the synchronized falling edge; no backpressure, byte is held until the next strobe.
module rs485_rx
   import rs485_pkg::*;
#(
   parameter logic PARITY_MODE = PARITY_MODE_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] dataout,
   output logic       rdsig,
   output logic       dataerror,
   output logic       frameerror,
   output logic       idle
);

   logic rx_s;
   logic rx_fall;

   rs485_rx_sync u_sync (
      .clk    (clk),
      .rst_n  (rst_n),
      .rx_i   (rx),
      .rx_s_o (rx_s),
      .fall_o (rx_fall)
   );

   rx_state_e         state_q;
   logic [TICK_W-1:0] tick_q;
   logic [2:0]        idx_q;
   logic              smp6_q;
   logic              smp7_q;
   logic [7:0]        shift_q;
   logic              par_q;
   logic [7:0]        dataout_q;
   logic              rdsig_q;
   logic              dataerror_q;
   logic              frameerror_q;
   logic              idle_q;

   logic smp_now;
   logic bit_smp;

   assign smp_now = (tick_q == SAMPLE_T2);
   assign bit_smp = maj3(smp6_q, smp7_q, rx_s);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         tick_q       <= '0;
         idx_q        <= '0;
         smp6_q       <= 1'b1;
         smp7_q       <= 1'b1;
         shift_q      <= '0;
         par_q        <= 1'b0;
         dataout_q    <= '0;
         rdsig_q      <= 1'b0;
         dataerror_q  <= 1'b0;
         frameerror_q <= 1'b0;
         idle_q       <= 1'b0;
      end else begin
         rdsig_q <= 1'b0;

         if (state_q != ST_IDLE) begin
            tick_q <= tick_q + TICK_W'(1);
            if (tick_q == SAMPLE_T0) smp6_q <= rx_s;
            if (tick_q == SAMPLE_T1) smp7_q <= rx_s;
         end

         case (state_q)
            ST_IDLE: begin
               // The detection cycle itself is tick 0, so the next cycle is tick 1.
               if (rx_fall) begin
                  state_q <= ST_START;
                  tick_q  <= TICK_W'(1);
                  idle_q  <= 1'b1;
               end
            end
            ST_START: begin
               if (smp_now) begin
                  if (bit_smp) begin
                     state_q <= ST_IDLE;
                     idle_q  <= 1'b0;
                  end else begin
                     state_q <= ST_DATA;
                     idx_q   <= '0;
                  end
               end
            end
            ST_DATA: begin
               if (smp_now) begin
                  shift_q <= {bit_smp, shift_q[7:1]};
                  idx_q   <= idx_q + 3'd1;
                  if (idx_q == 3'd7) state_q <= ST_PARITY;
               end
            end
            ST_PARITY: begin
               if (smp_now) begin
                  par_q   <= bit_smp;
                  state_q <= ST_STOP;
               end
            end
            ST_STOP: begin
               // Errored frames are still delivered; only false starts are dropped.
               if (smp_now) begin
                  state_q      <= ST_IDLE;
                  idle_q       <= 1'b0;
                  rdsig_q      <= 1'b1;
                  dataout_q    <= shift_q;
                  dataerror_q  <= ((^shift_q) ^ PARITY_MODE) != par_q;
                  frameerror_q <= ~bit_smp;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               idle_q  <= 1'b0;
            end
         endcase
      end
   end

   assign dataout    = dataout_q;
   assign rdsig      = rdsig_q;
   assign dataerror  = dataerror_q;
   assign frameerror = frameerror_q;
   assign idle       = idle_q;

endmodule

// File: tb/tb_rs485_rx.sv
// Bench for rs485_rx: even- and odd-parity instances share the rx line; strobes are scored against a queue.
module tb_rs485_rx;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic [7:0] dataout0, dataout1;
   logic       rdsig0, rdsig1, dataerror0, dataerror1, frameerror0, frameerror1, idle0, idle1;

   always #5 clk = ~clk;

   rs485_rx #(.PARITY_MODE(1'b0)) dut0 (
      .clk(clk), .rst_n(rst_n), .rx(rx), .dataout(dataout0), .rdsig(rdsig0),
      .dataerror(dataerror0), .frameerror(frameerror0), .idle(idle0)
   );

   rs485_rx #(.PARITY_MODE(1'b1)) dut1 (
      .clk(clk), .rst_n(rst_n), .rx(rx), .dataout(dataout1), .rdsig(rdsig1),
      .dataerror(dataerror1), .frameerror(frameerror1), .idle(idle1)
   );

   typedef struct {
      logic [7:0] d;
      logic       derr;
      logic       ferr;
      int         t;
   } exp_t;

   typedef struct {
      logic [7:0] d;
      logic       p;
      logic       de0;
      logic       de1;
   } vec_t;

   exp_t q0[$];
   exp_t q1[$];
   vec_t tbl[5];
   int   n_chk = 0;
   int   n_fail = 0;
   int   cyc = 0;
   int   n_strb0 = 0;

   initial forever begin
      @(posedge clk);
      cyc++;
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic on_strobe(input int id, input logic [7:0] d, input logic de, input logic fe);
      exp_t e;
      bit   empty;
      empty = (id == 0) ? (q0.size() == 0) : (q1.size() == 0);
      if (empty) begin
         n_chk++;
         n_fail++;
         $display("FAIL strobe%0d_unexpected: strobe at cycle %0d with data %0h, expected none", id, cyc, d);
      end else begin
         if (id == 0) e = q0.pop_front();
         else         e = q1.pop_front();
         chk($sformatf("dut%0d_dataout", id), {24'd0, d}, {24'd0, e.d});
         chk($sformatf("dut%0d_dataerror", id), {31'd0, de}, {31'd0, e.derr});
         chk($sformatf("dut%0d_frameerror", id), {31'd0, fe}, {31'd0, e.ferr});
         chk($sformatf("dut%0d_strobe_cycle", id), cyc, e.t);
      end
   endtask

   // Strobe monitor, sampling on the falling edge.
   initial forever begin
      @(negedge clk);
      if (rdsig0 === 1'b1) begin
         n_strb0++;
         on_strobe(0, dataout0, dataerror0, frameerror0);
      end
      if (rdsig1 === 1'b1) on_strobe(1, dataout1, dataerror1, frameerror1);
   end

   task automatic line(input logic v, input int n);
      repeat (n) begin
         rx = v;
         @(negedge clk);
      end
   endtask

   // glitch: line-clock offset within the frame whose level is inverted (-1 for none).
   task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int stop_len,
                             input int glitch, input bit push, input logic de0, input logic de1);
      logic [10:0] bits;
      int          pos;
      int          len;
      exp_t        e;
      bits   = {s, p, d, 1'b0};
      e.d    = d;
      e.ferr = ~s;
      e.t    = cyc + 171;
      if (push) begin
         e.derr = de0;
         q0.push_back(e);
         e.derr = de1;
         q1.push_back(e);
      end
      pos = 0;
      for (int k = 0; k < 11; k++) begin
         len = (k == 10) ? stop_len : 16;
         for (int j = 0; j < len; j++) begin
            rx = bits[k] ^ (pos == glitch);
            @(negedge clk);
            pos++;
         end
      end
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached, expected test completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int strb;

      tbl[0] = '{d: 8'hA5, p: 1'b1, de0: 1'b1, de1: 1'b0};
      tbl[1] = '{d: 8'h3C, p: 1'b0, de0: 1'b0, de1: 1'b1};
      tbl[2] = '{d: 8'hFF, p: 1'b0, de0: 1'b0, de1: 1'b1};
      tbl[3] = '{d: 8'h81, p: 1'b1, de0: 1'b1, de1: 1'b0};
      tbl[4] = '{d: 8'h6E, p: 1'b1, de0: 1'b0, de1: 1'b1};

      rst_n = 1'b0;
      rx    = 1'b1;
      repeat (3) @(negedge clk);
      chk("rst_dataout", {24'd0, dataout0}, 32'h00);
      chk("rst_rdsig", {31'd0, rdsig0}, 32'd0);
      chk("rst_dataerror", {31'd0, dataerror0}, 32'd0);
      chk("rst_frameerror", {31'd0, frameerror0}, 32'd0);
      chk("rst_idle", {31'd0, idle0}, 32'd0);
      rst_n = 1'b1;
      line(1'b1, 5);

      // 0xA5 with good even parity, checking the idle window around the frame.
      fork
         send_frame(8'hA5, 1'b0, 1'b1, 16, -1, 1'b1, 1'b0, 1'b1);
         begin
            repeat (2) @(negedge clk);
            chk("idle_at_E", {31'd0, idle0}, 32'd0);
            @(negedge clk);
            chk("idle_at_E+1", {31'd0, idle0}, 32'd1);
            repeat (167) @(negedge clk);
            chk("idle_at_E+168", {31'd0, idle0}, 32'd1);
            @(negedge clk);
            chk("idle_at_E+169", {31'd0, idle0}, 32'd0);
         end
      join
      line(1'b1, 10);

      for (int i = 0; i < 5; i++) begin
         send_frame(tbl[i].d, tbl[i].p, 1'b1, 16, -1, 1'b1, tbl[i].de0, tbl[i].de1);
         line(1'b1, 10);
      end

      // Stop bit low, then the line stays low: exactly one strobe until it rises again.
      send_frame(8'h0F, 1'b0, 1'b0, 16, -1, 1'b1, 1'b0, 1'b1);
      line(1'b0, 20);
      strb = n_strb0;
      line(1'b0, 150);
      chk("stuck_low_no_strobe", n_strb0, strb);
      chk("stuck_low_frameerror_held", {31'd0, frameerror0}, 32'd1);
      chk("stuck_low_dataout_held", {24'd0, dataout0}, 32'h0F);
      line(1'b1, 20);
      send_frame(8'h3C, 1'b0, 1'b1, 16, -1, 1'b1, 1'b0, 1'b1);
      line(1'b1, 10);

      // False start: 5 low clocks.
      fork
         begin
            line(1'b0, 5);
            line(1'b1, 20);
         end
         begin
            repeat (3) @(negedge clk);
            chk("false_idle_E+1", {31'd0, idle0}, 32'd1);
            repeat (7) @(negedge clk);
            chk("false_idle_E+8", {31'd0, idle0}, 32'd1);
            @(negedge clk);
            chk("false_idle_E+9", {31'd0, idle0}, 32'd0);
         end
      join
      chk("false_dataout_kept", {24'd0, dataout0}, 32'h3C);
      chk("false_frameerror_kept", {31'd0, frameerror0}, 32'd0);

      // One-clock glitch at tick 7 of data bit 3.
      send_frame(8'h00, 1'b0, 1'b1, 16, 71, 1'b1, 1'b0, 1'b1);
      line(1'b1, 10);

      // Back-to-back with short stop bits; next start 2 clocks after the stop.
      send_frame(8'h00, 1'b1, 1'b1, 8, -1, 1'b1, 1'b1, 1'b0);
      line(1'b1, 2);
      send_frame(8'hFF, 1'b1, 1'b1, 8, -1, 1'b1, 1'b1, 1'b0);
      line(1'b1, 20);

      // Reset at E+80 of 0x55; held until the line is idle again.
      fork
         send_frame(8'h55, 1'b0, 1'b1, 16, -1, 1'b0, 1'b0, 1'b0);
         begin
            repeat (82) @(negedge clk);
            chk("pre_reset_idle", {31'd0, idle0}, 32'd1);
            rst_n = 1'b0;
            #1;
            chk("midrst_dataout", {24'd0, dataout0}, 32'h00);
            chk("midrst_dataerror", {31'd0, dataerror0}, 32'd0);
            chk("midrst_idle", {31'd0, idle0}, 32'd0);
            chk("midrst_idle_dut1", {31'd0, idle1}, 32'd0);
         end
      join
      line(1'b1, 4);
      chk("midrst_frameerror", {31'd0, frameerror0}, 32'd0);
      chk("midrst_rdsig", {31'd0, rdsig0}, 32'd0);
      rst_n = 1'b1;
      line(1'b1, 10);

      send_frame(8'hC3, 1'b0, 1'b1, 16, -1, 1'b1, 1'b0, 1'b1);
      line(1'b1, 20);

      chk("final_dataout_held", {24'd0, dataout0}, 32'hC3);
      chk("pending_strobes_dut0", q0.size(), 32'd0);
      chk("pending_strobes_dut1", q1.size(), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
